// File: rtl/uart_rx_deframer_if.sv
// Byte handshake between the UART receiver and its consumer.
// The receiver drives the data and valid signals. The consumer drives ready.
interface uart_rx_deframer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver. It samples each bit at mid-bit and uses a one-entry
// ready/valid output register. It flags framing errors and overruns with
// one-cycle pulses. A break condition (line held low) is parked in WAIT_HIGH
// so that it cannot start spurious frames.
module uart_rx_deframer #(
    parameter int kClkHz = 50_000_000,
    parameter int kBaud  = 115200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_in,
    uart_rx_deframer_if.master         rx_if,
    output logic                       busy,
    output logic                       frame_err,
    output logic                       overrun
);

    localparam int CPB = kClkHz / kBaud;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] kHalfLast = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] kBitLast  = CW'(CPB - 1);

    if (CPB < 4) begin : g_bad_cpb
        $error("uart_rx_deframer: clocks per bit must be at least 4");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    logic [1:0]    sync_q;
    logic          rxs;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          deliver;
    logic          ferr_d;
    logic [7:0]    data_q;
    logic          valid_q;

    // Two-flop synchroniser. It resets to the idle-high line level.
    always_ff @(posedge clk) begin
        // NOTE: use non-blocking assignments for every flop so that all registers update together on the edge.
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], rx_in};
    end

    assign rxs = sync_q[1];

    // Frame FSM state, counters and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state logic: the bit timing, the mid-bit sampling and the stop-bit verdict.
    always_comb begin
        // NOTE: assign every output a default first so that no path leaves a signal unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shreg_d = shreg_q;
        deliver = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt_q == kHalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A line that is high again at mid-start is treated as a glitch.
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == kBitLast) begin
                    cnt_d   = '0;
                    shreg_d = {rxs, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cnt_q == kBitLast) begin
                    cnt_d = '0;
                    if (rxs) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Output register and the status pulses. A simultaneous accept makes room for the new byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_d;
            overrun   <= deliver && valid_q && !rx_if.rx_ready;
            if (deliver && (!valid_q || rx_if.rx_ready)) begin
                data_q  <= shreg_q;
                valid_q <= 1'b1;
            end else if (valid_q && rx_if.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign busy           = (state_q != IDLE);

endmodule
